// File: rtl/vdp_io.sv
// CPU port block for a TMS9918-compatible VDP: I/O decode, the two-byte control sequence,
// mode registers, auto-incrementing VRAM address, read-ahead buffer and status/interrupt flags.
module vdp_io #(
    parameter int          ADDR_BITS = 14,
    parameter logic [7:0]  PORT_DATA = 8'h98,
    parameter logic [7:0]  PORT_CTRL = 8'h99
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_ce,
    input  logic [7:0]           io_addr,
    input  logic                 io_wr_n,
    input  logic                 io_rd_n,
    input  logic [7:0]           cpu_dout,
    output logic [7:0]           cpu_din,
    output logic                 cpu_sel,
    output logic [ADDR_BITS-1:0] vram_addr,
    output logic [7:0]           vram_wdata,
    output logic                 vram_we,
    output logic                 vram_re,
    input  logic [7:0]           vram_rdata,
    output logic [63:0]          vdp_regs,
    input  logic                 frame_evt,
    input  logic                 coll_evt,
    input  logic                 fifth_evt,
    input  logic [4:0]           fifth_num,
    output logic                 n_int
);
    typedef enum logic [1:0] {IDLE, FETCH, CAPT} state_t;

    state_t              state, state_n;
    logic [7:0][7:0]     regs;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]          rbuf, first;
    logic                second, f_flag, c_flag, s5_flag;
    logic [4:0]          fnum;
    logic                pend, pend_wr, pend_n, pend_wr_n, we_n, re_n;
    logic [3:0]          sel, sel_q, start, fin;
    logic                hit_data, hit_ctrl;
    logic                wr_data_s, wr_ctrl_s, rd_data_e, rd_ctrl_e;
    logic                req_wr, req_pf, can_issue;

    assign hit_data = (io_addr == PORT_DATA);
    assign hit_ctrl = (io_addr == PORT_CTRL);
    // {rd ctrl, rd data, wr ctrl, wr data}
    assign sel   = {~io_rd_n & hit_ctrl, ~io_rd_n & hit_data, ~io_wr_n & hit_ctrl, ~io_wr_n & hit_data};
    assign start = {4{cpu_ce}} & sel & ~sel_q;
    assign fin   = {4{cpu_ce}} & ~sel & sel_q;

    assign wr_data_s = start[0];
    assign wr_ctrl_s = start[1];
    assign rd_data_e = fin[2];
    assign rd_ctrl_e = fin[3];

    assign req_wr = wr_data_s;
    assign req_pf = (wr_ctrl_s & second & ~cpu_dout[7] & ~cpu_dout[6]) | rd_data_e;

    assign vram_addr = addr;
    assign vdp_regs  = regs;
    assign cpu_sel   = sel[2] | sel[3];

    always_comb begin
        cpu_din = 8'hFF;
        if (sel[2])
            cpu_din = rbuf;
        else if (sel[3])
            cpu_din = {f_flag, s5_flag, c_flag, s5_flag ? fnum : 5'h1F};
    end

    // The write pulse cycle counts as busy so a queued op never overlaps the address bump.
    always_comb begin
        state_n   = state;
        we_n      = 1'b0;
        re_n      = 1'b0;
        pend_n    = pend;
        pend_wr_n = pend_wr;
        can_issue = (state == IDLE) && !vram_we;
        case (state)
            FETCH:   state_n = CAPT;
            CAPT:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (can_issue && pend) begin
            pend_n    = 1'b0;
            can_issue = 1'b0;
            if (pend_wr) we_n = 1'b1;
            else begin
                re_n    = 1'b1;
                state_n = FETCH;
            end
        end
        if (req_wr || req_pf) begin
            if (can_issue) begin
                if (req_wr) we_n = 1'b1;
                else begin
                    re_n    = 1'b1;
                    state_n = FETCH;
                end
            end else if (!pend_n) begin
                pend_n    = 1'b1;
                pend_wr_n = req_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            regs       <= '0;
            addr       <= '0;
            rbuf       <= 8'h00;
            first      <= 8'h00;
            second     <= 1'b0;
            f_flag     <= 1'b0;
            c_flag     <= 1'b0;
            s5_flag    <= 1'b0;
            fnum       <= 5'h00;
            pend       <= 1'b0;
            pend_wr    <= 1'b0;
            vram_we    <= 1'b0;
            vram_re    <= 1'b0;
            vram_wdata <= 8'h00;
            sel_q      <= 4'h0;
            n_int      <= 1'b1;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            pend_wr <= pend_wr_n;
            vram_we <= we_n;
            vram_re <= re_n;
            if (cpu_ce) sel_q <= sel;

            if (vram_we || state == CAPT) addr <= addr + ADDR_BITS'(1);
            if (state == CAPT) rbuf <= vram_rdata;

            if (wr_data_s) begin
                rbuf       <= cpu_dout;
                vram_wdata <= cpu_dout;
            end

            if (wr_ctrl_s) begin
                second <= ~second;
                if (!second)
                    first <= cpu_dout;
                else if (cpu_dout[7])
                    regs[cpu_dout[2:0]] <= first;
                else
                    addr <= ADDR_BITS'({cpu_dout[5:0], first});
            end
            if (wr_data_s || rd_data_e || rd_ctrl_e) second <= 1'b0;

            // Event sets take priority over the status-read clear.
            if (frame_evt)      f_flag <= 1'b1;
            else if (rd_ctrl_e) f_flag <= 1'b0;
            if (coll_evt)       c_flag <= 1'b1;
            else if (rd_ctrl_e) c_flag <= 1'b0;
            if (fifth_evt && (!s5_flag || rd_ctrl_e)) begin
                s5_flag <= 1'b1;
                fnum    <= fifth_num;
            end else if (rd_ctrl_e) begin
                s5_flag <= 1'b0;
            end

            n_int <= ~(f_flag & regs[1][5]);
        end
    end
endmodule

// File: tb/tb_vdp_io.sv
// Directed bench for vdp_io: table of CPU port accesses plus hand sequences for timing and flags.
module tb_vdp_io;
    logic        clk = 1'b0;
    logic        reset, cpu_ce, io_wr_n, io_rd_n;
    logic [7:0]  io_addr, cpu_dout, cpu_din, vram_wdata, vram_rdata;
    logic        cpu_sel, vram_we, vram_re, frame_evt, coll_evt, fifth_evt, n_int;
    logic [13:0] vram_addr;
    logic [63:0] vdp_regs;
    logic [4:0]  fifth_num;

    logic [7:0]  mem [0:16383];
    int          we_cnt = 0, re_cnt = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        bit          rd;
        logic [7:0]  port;
        logic [7:0]  data;
        logic [7:0]  din;
        logic [13:0] addr;
        logic [63:0] regs;
    } vec_t;
    vec_t tbl [20];

    vdp_io dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .io_addr(io_addr),
        .io_wr_n(io_wr_n), .io_rd_n(io_rd_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .cpu_sel(cpu_sel), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata),
        .vdp_regs(vdp_regs), .frame_evt(frame_evt), .coll_evt(coll_evt),
        .fifth_evt(fifth_evt), .fifth_num(fifth_num), .n_int(n_int)
    );

    always #5 clk = ~clk;

    // VRAM model: read data appears one clock after vram_re
    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (vram_re) begin
            vram_rdata <= mem[vram_addr];
            re_cnt <= re_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tstate();
        cpu_ce = 1'b1;
        tick();
        cpu_ce = 1'b0;
        repeat (3) tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic io_op(input bit rd, input logic [7:0] port, input logic [7:0] data,
                         output logic [7:0] din);
        io_addr  = port;
        cpu_dout = data;
        if (rd) io_rd_n = 1'b0;
        else    io_wr_n = 1'b0;
        tstate();
        din = cpu_din;
        tstate();
        tstate();
        io_rd_n = 1'b1;
        io_wr_n = 1'b1;
        tstate();
        tstate();
    endtask

    initial begin
        logic [7:0] d;
        tbl[0]  = '{0, 8'h99, 8'h40, 8'h00, 14'h0000, 64'h0};
        tbl[1]  = '{0, 8'h99, 8'h81, 8'h00, 14'h0000, 64'h4000};
        tbl[2]  = '{0, 8'h99, 8'h00, 8'h00, 14'h0000, 64'h4000};
        tbl[3]  = '{0, 8'h99, 8'h40, 8'h00, 14'h0000, 64'h4000};
        tbl[4]  = '{0, 8'h98, 8'hAA, 8'h00, 14'h0001, 64'h4000};
        tbl[5]  = '{0, 8'h98, 8'hBB, 8'h00, 14'h0002, 64'h4000};
        tbl[6]  = '{0, 8'h99, 8'h34, 8'h00, 14'h0002, 64'h4000};
        tbl[7]  = '{0, 8'h99, 8'h52, 8'h00, 14'h1234, 64'h4000};
        tbl[8]  = '{0, 8'h98, 8'h5A, 8'h00, 14'h1235, 64'h4000};
        tbl[9]  = '{0, 8'h98, 8'hC3, 8'h00, 14'h1236, 64'h4000};
        tbl[10] = '{0, 8'h99, 8'h34, 8'h00, 14'h1236, 64'h4000};
        tbl[11] = '{0, 8'h99, 8'h12, 8'h00, 14'h1235, 64'h4000};
        tbl[12] = '{1, 8'h98, 8'h00, 8'h5A, 14'h1236, 64'h4000};
        tbl[13] = '{1, 8'h98, 8'h00, 8'hC3, 14'h1237, 64'h4000};
        tbl[14] = '{0, 8'h99, 8'hFF, 8'h00, 14'h1237, 64'h4000};
        tbl[15] = '{0, 8'h99, 8'h7F, 8'h00, 14'h3FFF, 64'h4000};
        tbl[16] = '{0, 8'h98, 8'h11, 8'h00, 14'h0000, 64'h4000};
        tbl[17] = '{0, 8'h98, 8'h22, 8'h00, 14'h0001, 64'h4000};
        tbl[18] = '{0, 8'h99, 8'h60, 8'h00, 14'h0001, 64'h4000};
        tbl[19] = '{0, 8'h99, 8'h81, 8'h00, 14'h0001, 64'h6000};

        reset = 1'b1; cpu_ce = 1'b0; io_wr_n = 1'b1; io_rd_n = 1'b1;
        io_addr = 8'h00; cpu_dout = 8'h00; frame_evt = 1'b0; coll_evt = 1'b0;
        fifth_evt = 1'b0; fifth_num = 5'h00;
        repeat (3) tick();
        chk("reset_regs", vdp_regs, 64'h0);
        chk("reset_addr", 64'(vram_addr), 64'h0);
        chk("reset_nint", 64'(n_int), 64'h1);
        chk("reset_pulses", 64'({vram_we, vram_re}), 64'h0);
        chk("reset_sel", 64'(cpu_sel), 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            io_op(tbl[i].rd, tbl[i].port, tbl[i].data, d);
            if (tbl[i].rd) chk($sformatf("row%0d_din", i), 64'(d), 64'(tbl[i].din));
            chk($sformatf("row%0d_addr", i), 64'(vram_addr), 64'(tbl[i].addr));
            chk($sformatf("row%0d_regs", i), vdp_regs, tbl[i].regs);
        end
        chk("mem_wrap0", 64'(mem[14'h0000]), 64'h22);
        chk("mem_1", 64'(mem[14'h0001]), 64'hBB);
        chk("mem_3fff", 64'(mem[14'h3FFF]), 64'h11);
        chk("we_count", 64'(we_cnt), 64'd6);
        chk("re_count", 64'(re_cnt), 64'd3);

        // data write pulse timing at address 1
        io_addr = 8'h98; cpu_dout = 8'h77; io_wr_n = 1'b0; cpu_ce = 1'b1;
        chk("wr_pre_we", 64'(vram_we), 64'h0);
        tick();
        cpu_ce = 1'b0;
        chk("wr_we", 64'({vram_we, vram_addr, vram_wdata}), 64'({1'b1, 14'h0001, 8'h77}));
        tick();
        chk("wr_post", 64'({vram_we, vram_addr}), 64'({1'b0, 14'h0002}));
        repeat (2) tick();
        tstate();
        io_wr_n = 1'b1;
        tstate(); tstate();

        // register write latency: R2 <= 0x5E
        io_op(0, 8'h99, 8'h5E, d);
        io_addr = 8'h99; cpu_dout = 8'h82; io_wr_n = 1'b0; cpu_ce = 1'b1;
        chk("r2_before", 64'(vdp_regs[23:16]), 64'h00);
        tick();
        cpu_ce = 1'b0;
        chk("r2_after", 64'(vdp_regs[23:16]), 64'h5E);
        repeat (3) tick();
        tstate();
        io_wr_n = 1'b1;
        tstate(); tstate();

        // vblank interrupt with R1[5]=1
        frame_evt = 1'b1;
        tick();
        frame_evt = 1'b0;
        chk("nint_lat", 64'(n_int), 64'h1);
        tick();
        chk("nint_low", 64'(n_int), 64'h0);
        io_op(1, 8'h99, 8'h00, d);
        chk("status_f", 64'(d), 64'h9F);
        chk("nint_clr", 64'(n_int), 64'h1);

        // collision + fifth sprite; a second fifth event must not relatch
        coll_evt = 1'b1; fifth_evt = 1'b1; fifth_num = 5'h07;
        tick();
        coll_evt = 1'b0; fifth_num = 5'h0A;
        tick();
        fifth_evt = 1'b0;
        tick();
        io_op(1, 8'h99, 8'h00, d);
        chk("status_c5s", 64'(d), 64'h67);
        io_op(1, 8'h99, 8'h00, d);
        chk("status_clr", 64'(d), 64'h1F);

        // frame event coinciding with the status-read end keeps F
        io_addr = 8'h99; io_rd_n = 1'b0;
        tstate();
        io_rd_n = 1'b1; cpu_ce = 1'b1; frame_evt = 1'b1;
        tick();
        cpu_ce = 1'b0; frame_evt = 1'b0;
        repeat (3) tick();
        io_op(1, 8'h99, 8'h00, d);
        chk("status_setwins", 64'(d), 64'h9F);

        // status read clears the half-written control sequence
        io_op(0, 8'h99, 8'h55, d);
        io_op(1, 8'h99, 8'h00, d);
        chk("status_after", 64'(d), 64'h1F);
        io_op(0, 8'h99, 8'h3C, d);
        io_op(0, 8'h99, 8'h87, d);
        chk("second_clr", vdp_regs, 64'h3C00_0000_005E_6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vdp_io.md
# vdp_io

CPU-side port block for the TMS9918-compatible VDP. It decodes Z80 I/O accesses to ports 0x98 (data) and 0x99 (control/status) and performs the two-byte control-write sequence. It owns the eight VDP mode registers, the auto-incrementing VRAM address, the read-ahead buffer and the status/interrupt flags. It sits between the CPU bus and the `video` module, driving its VRAM port and mode inputs and consuming its frame/sprite event outputs.

## Interface
- `ADDR_BITS`, default 14: VRAM address width.
- `PORT_DATA`, default 8'h98: data port number.
- `PORT_CTRL`, default 8'h99: control/status port number.

Ports:
- `clk`  in  1  system clock (cpuClock domain)
- `reset`  in  1  synchronous, active-high
- `cpu_ce`  in  1  one-cycle strobe per CPU T-state; all bus sampling occurs only on `cpu_ce`
- `io_addr`  in  8  CPU address[7:0]
- `io_wr_n`, `io_rd_n`  in  1  active-low I/O write/read (already qualified with IORQ)
- `cpu_dout`  in  8  CPU write data
- `cpu_din`  out  8  read data; combinational, valid while a port read is active
- `cpu_sel`  out  1  high while `io_rd_n`=0 and `io_addr` is `PORT_DATA` or `PORT_CTRL`
- `vram_addr`  out  ADDR_BITS  VRAM address for the current operation
- `vram_wdata`  out  8  VRAM write data
- `vram_we`, `vram_re`  out  1  one-clk VRAM write/read pulses
- `vram_rdata`  in  8  VRAM read data, valid exactly 1 clk after `vram_re`
- `vdp_regs`  out  64  R0..R7; R*n* occupies bits [8n+7:8n]
- `frame_evt`  in  1  one-clk vblank event
- `coll_evt`  in  1  one-clk sprite-collision event
- `fifth_evt`  in  1  one-clk fifth-sprite event
- `fifth_num`  in  5  sprite number for `fifth_evt`
- `n_int`  out  1  active-low interrupt request

## Operation
- Access edges, sampled on `cpu_ce` against a registered previous select:
  - Start: the select goes from 0 to 1.
  - End: the select goes from 1 to 0.
  - Each access acts exactly once, however many T-states it lasts.
- Write to `PORT_DATA` (start): issue a VRAM write at the current address; load the read buffer with the written data; increment the address; clear `second`.
- Write to `PORT_CTRL` (start):
  - `second`=0: latch `cpu_dout` into `first`; set `second`.
  - `second`=1, bit7=1: write R[`cpu_dout`[2:0]] <= `first`; bits 6:3 are ignored.
  - `second`=1, bit7=0: address <= {`cpu_dout`[5:0], `first`}. If bit6=0, also issue a prefetch (read-ahead).
  - `second` toggles back to 0 in both `second`=1 cases.
- Read of `PORT_DATA`:
  - `cpu_din` = read buffer.
  - At end: issue a prefetch; clear `second`.
- Read of `PORT_CTRL`:
  - `cpu_din` = {F, 5S, C, `fifth_num_latched`}. `fifth_num_latched` reads 5'h1F when 5S=0.
  - At end: clear F, 5S and C; clear `second`.
- Status flags:
  - `frame_evt` sets F.
  - `coll_evt` sets C.
  - `fifth_evt` sets 5S and latches `fifth_num`, only if 5S=0.
  - A set and a clear in the same clk: the set wins.
- `n_int` = ~(F & R1[5]), registered.
- VRAM op FSM:
  - States: IDLE, FETCH, CAPT.
  - Write: IDLE -> pulse `vram_we` -> IDLE.
  - Prefetch: IDLE -> FETCH (`vram_re`=1) -> CAPT (buffer <= `vram_rdata`; address+1) -> IDLE.
  - A request arriving while not IDLE sets a one-deep `pending`, issued on return to IDLE.
  - A second request while `pending` is set is dropped. This cannot occur when `cpu_ce` spacing is ≥4 clk.
- Address arithmetic: modulo 2^ADDR_BITS; 0x3FFF+1 wraps to 0x0000.
- Write and prefetch each increment the address exactly once.

## Timing
- Reset values:
  - `vdp_regs`=0, address=0, read buffer=0, `first`=0.
  - `second`=0, F=C=5S=0, FSM=IDLE, `pending`=0.
  - `vram_we`=`vram_re`=0, `n_int`=1.
- Register write: `vdp_regs` updates 1 clk after the `cpu_ce` that sees the second-byte start.
- Data write: `vram_we` asserts 1 clk after the start `cpu_ce`, with `vram_addr`/`vram_wdata` stable in that cycle. The address increments in the following clk.
- Prefetch: `vram_re` asserts 1 clk after the triggering edge. The buffer is valid and the address incremented 2 clk after `vram_re`.
- `n_int` follows F/R1[5] with 1 clk latency.
- `cpu_din`/`cpu_sel` are combinational from `io_addr`/`io_rd_n` and the registered state.
- Reset mid-operation: reset aborts the FSM and drops `pending`; no pulse is emitted in the reset cycle.

## Test plan
- Reset, then write 0x99 twice with 0x40, 0x81 -> R1=0x40 1 clk later; `second`=0; no VRAM pulses.
- Write 0x99 with 0x00, 0x40, then 0x98 with 0xAA, 0xBB -> `vram_we` at 0x0000=0xAA and 0x0001=0xBB; final address 0x0002.
- Preload VRAM[0x1234]=0x5A, [0x1235]=0xC3. Write 0x99 with 0x34, 0x12 -> buffer=0x5A. Read 0x98 -> 0x5A, then buffer=0xC3; address=0x1236.
- Set address 0x3FFF for write; write 0x98 -> the next write lands at 0x0000.
- R1[5]=1; pulse `frame_evt` -> `n_int`=0 1 clk later. Read 0x99 -> 0x9F. After the access end, F=0 and `n_int`=1.
- `frame_evt` in the same clk as the status-read end -> F stays 1. Write 0x99 one byte, then read 0x99 -> `second` cleared; the next 0x99 write is treated as a first byte.
